// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param.
// The FIFO connects through the slave modport; the master side drives requests and observes status.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    count;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, almost_full, almost_empty, overflow, underflow, count
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, almost_full, almost_empty, overflow, underflow, count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with explicit fill count, registered flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read (latency 1).
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic             clk,
  input  logic             res,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          almost_full_reg;
  logic          almost_empty_reg;
  logic          overflow_reg;
  logic          underflow_reg;
  logic          wr_accept;
  logic          rd_accept;

  // A read at full frees the slot the same edge, so the write is still taken.
  assign wr_accept = bus.wr_en && (!full_reg || bus.rd_en);
  assign rd_accept = bus.rd_en && !empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Flags are registered from count_next so they line up with count every cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg        <= count_next;
      full_reg         <= (count_next == FULL_LEVEL);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_LEVEL);
      almost_empty_reg <= (count_next <= AE_LEVEL);
      overflow_reg     <= bus.wr_en && full_reg && !bus.rd_en;
      underflow_reg    <= bus.rd_en && empty_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept && !res) mem[wr_ptr_reg] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is visible combinationally; forced to zero while nothing is stored.
  assign bus.rdata = empty_reg ? '0 : mem[rd_ptr_reg];
`else
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (res) begin
      rdata_reg <= '0;
    end else if (rd_accept) begin
      rdata_reg <= mem[rd_ptr_reg];
    end
  end

  assign bus.rdata = rdata_reg;
`endif

  assign bus.count        = count_reg;
  assign bus.full         = full_reg;
  assign bus.empty        = empty_reg;
  assign bus.almost_full  = almost_full_reg;
  assign bus.almost_empty = almost_empty_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised synchronous FIFO. It is the next generation of the team's FIFO block.
- Adds configurable width and depth, a fill-level count, programmable almost-full and almost-empty flags, and defined simultaneous read/write behaviour at the full and empty boundaries.
- Sits between a producer and a consumer in the same clock domain.
- Overflow and underflow are reported as single-cycle error pulses.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of entries. Must be a power of 2 and at least 4.
- AF_MARGIN, 2: almost_full asserts when count >= DEPTH-AF_MARGIN. Range 1..DEPTH-1.
- AE_MARGIN, 2: almost_empty asserts when count <= AE_MARGIN. Range 1..DEPTH-1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- res  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wdata  input  WIDTH  write data.
- rd_en  input  1  read request.
- rdata  output  WIDTH  read data.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- almost_full  output  1  fill level at or above the high threshold.
- almost_empty  output  1  fill level at or below the low threshold.
- overflow  output  1  one-cycle pulse: a write was dropped.
- underflow  output  1  one-cycle pulse: a read was ignored.
- count  output  $clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Interface: one clock (clk); reset res is synchronous and active-high.
- Reset (res=1 at posedge):
  - wr_ptr, rd_ptr and count go to 0.
  - rdata=0, full=0, overflow=0, underflow=0, almost_full=0.
  - empty=1, almost_empty=1.
  - Memory contents are don't-care.
  - Reset has priority over wr_en and rd_en. A reset mid-operation discards all entries the next cycle.
- Pointers:
  - Width $clog2(DEPTH); they wrap naturally from DEPTH-1 to 0.
  - count is tracked explicitly, not derived from pointer difference.
- Write accepted when wr_en && (!full || rd_en):
  - mem[wr_ptr] <= wdata; wr_ptr increments.
- Read accepted when rd_en && !empty:
  - rdata <= mem[rd_ptr] on the same edge, so data is valid the cycle after rd_en (latency 1).
  - rd_ptr increments.
  - rdata holds its last value when no read is accepted.
- count update:
  - +1 for write only, -1 for read only, unchanged for both or neither.
- Full boundary, wr_en and rd_en both high:
  - Both are accepted; count stays DEPTH; overflow=0.
- Empty boundary, wr_en and rd_en both high:
  - Write is accepted; read is ignored.
  - underflow pulses; count becomes 1; rdata is unchanged.
- overflow: registered pulse, high the cycle after wr_en && full && !rd_en.
- underflow: registered pulse, high the cycle after rd_en && empty.
- Flags:
  - All flags (full, empty, almost_full, almost_empty) are registered from next-count.
  - They are therefore coherent with count in the same cycle; there is no combinational path from wr_en or rd_en to any flag.
  - full = (count==DEPTH); empty = (count==0).
- No state machine beyond the pointers and counter. Illegal states cannot occur; count never exceeds DEPTH.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rdata continuously presents mem[rd_ptr] (asynchronous memory read) whenever !empty, with 0 read latency.
  - rd_en acknowledges and pops the head; rdata shows the next entry in the following cycle.
  - rdata=0 while empty. Reset value is 0.
  - All flag, count and underflow behaviour is identical to standard mode.
- Undefined: standard registered read with latency 1, as described in Behaviour.

Test Plan:
- Reset: assert res for 2 cycles with wr_en=rd_en=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, rdata=0.
- Fill: 16 writes of 0x01..0x10 (DEPTH=16) -> almost_full rises when count=14, full rises when count=16. A 17th write with rd_en=0 -> overflow pulses one cycle; count stays 16; 0x11 is not stored.
- Drain:
  - 16 reads -> rdata sequence 0x01..0x10, each valid one cycle after rd_en.
  - almost_empty rises at count=2; empty rises at count=0.
  - One extra read -> underflow pulses; rdata holds 0x10.
- Wrap-around: 10 writes, 10 reads, then 16 writes and 16 reads -> data order preserved across pointer wrap; count returns to 0.
- Simultaneous read and write:
  - At full, write 0xAA while reading -> count stays 16; overflow=0; head word pops.
  - At empty, write 0x55 while reading -> underflow=1; count=1; next read returns 0x55.
- FWFT (SYNC_FIFO_FWFT_EN defined):
  - Write 0x3C into an empty FIFO -> rdata=0x3C the cycle after the write, with no rd_en.
  - rd_en pops it -> empty=1, rdata=0.
  - Mid-operation reset with 5 entries -> count=0 next cycle.
